// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage buffer.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [31:0] NOP_IR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage buffer with instruction and side channels.
// Macro PIPE_STAGE_SKID_EN adds a skid slot and a registered in_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W = DATA_W_DEF,
  parameter int unsigned          NUM_CH = 3,
  parameter logic [DATA_W-1:0]    NOP_IR = DATA_W'(NOP_IR_DEF),
  parameter int unsigned          CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_ir,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_ir,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned BUS_W = NUM_CH * DATA_W;

  stage_state_e      state, state_nxt;
  logic [DATA_W-1:0] main_ir, main_ir_nxt;
  logic [BUS_W-1:0]  main_data, main_data_nxt;
  logic              in_xfer_c;
  logic              out_xfer_c;

  assign in_xfer_c  = in_valid & in_ready;
  assign out_xfer_c = out_valid & out_ready;
  assign out_valid  = (state != EMPTY);
  assign out_ir     = main_ir;
  assign out_data   = main_data;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_ir, skid_ir_nxt;
  logic [BUS_W-1:0]  skid_data, skid_data_nxt;
  logic              ready_q, ready_nxt;

  assign in_ready = ready_q;
`else
  // Single slot: room exists if empty or the held entry leaves this cycle.
  assign in_ready = ~out_valid | out_ready;
`endif

  // Next-state and slot movement; flush overrides every handshake.
  always_comb begin
    state_nxt     = state;
    main_ir_nxt   = main_ir;
    main_data_nxt = main_data;
`ifdef PIPE_STAGE_SKID_EN
    skid_ir_nxt   = skid_ir;
    skid_data_nxt = skid_data;
    ready_nxt     = ready_q;
`endif
    if (flush) begin
      state_nxt     = EMPTY;
      main_ir_nxt   = NOP_IR;
      main_data_nxt = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ir_nxt   = NOP_IR;
      skid_data_nxt = '0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer_c) begin
            state_nxt     = ONE;
            main_ir_nxt   = in_ir;
            main_data_nxt = in_data;
          end
        end
        ONE: begin
          if (in_xfer_c && out_xfer_c) begin
            main_ir_nxt   = in_ir;
            main_data_nxt = in_data;
          end else if (out_xfer_c) begin
            state_nxt     = EMPTY;
            main_ir_nxt   = NOP_IR;
            main_data_nxt = '0;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (in_xfer_c) begin
            state_nxt     = FULL;
            skid_ir_nxt   = in_ir;
            skid_data_nxt = in_data;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (out_xfer_c) begin
            state_nxt     = ONE;
            main_ir_nxt   = skid_ir;
            main_data_nxt = skid_data;
            skid_ir_nxt   = NOP_IR;
            skid_data_nxt = '0;
          end
        end
`endif
        default: begin
          state_nxt     = EMPTY;
          main_ir_nxt   = NOP_IR;
          main_data_nxt = '0;
        end
      endcase
    end
`ifdef PIPE_STAGE_SKID_EN
    ready_nxt = (state_nxt != FULL);
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= EMPTY;
      main_ir   <= NOP_IR;
      main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ir   <= NOP_IR;
      skid_data <= '0;
      ready_q   <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      main_ir   <= main_ir_nxt;
      main_data <= main_data_nxt;
`ifdef PIPE_STAGE_SKID_EN
      skid_ir   <= skid_ir_nxt;
      skid_data <= skid_data_nxt;
      ready_q   <= ready_nxt;
`endif
    end
  end

  // Back-pressure cycles; survives flush, cleared only by clr.
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (clr),
    .en    (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios then random traffic
// against a queue-based reference model (depth follows PIPE_STAGE_SKID_EN).
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 3;
  localparam int unsigned BW = NC * DW;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr, in_valid, flush, out_ready;
  logic [DW-1:0] in_ir;
  logic [BW-1:0] in_data;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_ir;
  logic [BW-1:0] out_data;
  logic [15:0]   stall_cnt;

  logic          in_ready4, out_valid4;
  logic [DW-1:0] out_ir4;
  logic [BW-1:0] out_data4;
  logic [3:0]    stall_cnt4;

  pipe_stage_buf #(
    .DATA_W(DW), .NUM_CH(NC), .NOP_IR(NOP_IR_DEF), .CNT_W(16)
  ) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(
    .DATA_W(DW), .NUM_CH(NC), .NOP_IR(NOP_IR_DEF), .CNT_W(4)
  ) dut4 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4),
    .in_ir(in_ir), .in_data(in_data), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .out_ir(out_ir4),
    .out_data(out_data4), .stall_cnt(stall_cnt4)
  );

  typedef struct packed {
    logic [DW-1:0] ir;
    logic [BW-1:0] data;
  } ent_t;

  ent_t        q[$];
  int unsigned st16 = 0;
  int unsigned st4  = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic logic exp_ready();
    if (CAP == 2) return (q.size() < 2);
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] ir, input logic [BW-1:0] d,
                       input logic fl, input logic ordy, input logic c);
    in_valid  = iv;
    in_ir     = ir;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    clr       = c;
  endtask

  task automatic model_edge(input logic ix, input logic ox, input logic stalled);
    if (clr) begin
      q.delete();
      st16 = 0;
      st4  = 0;
    end else begin
      if (stalled) begin
        if (st16 < 65535) st16++;
        if (st4 < 15) st4++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (ox) void'(q.pop_front());
        if (ix) q.push_back('{ir: in_ir, data: in_data});
      end
    end
  endtask

  // One cycle: check outputs at the falling edge, then advance the model.
  task automatic tick();
    logic          ix, ox, stalled;
    logic [DW-1:0] e_ir;
    logic [BW-1:0] e_data;
    @(negedge clk);
    e_ir   = NOP_IR_DEF;
    e_data = '0;
    if (q.size() > 0) begin
      e_ir   = q[0].ir;
      e_data = q[0].data;
    end
    check("out_valid", BW'(out_valid), BW'(q.size() > 0));
    check("out_ir", BW'(out_ir), BW'(e_ir));
    check("out_data", out_data, e_data);
    check("in_ready", BW'(in_ready), BW'(exp_ready()));
    check("stall_cnt", BW'(stall_cnt), BW'(st16));
    check("stall_cnt4", BW'(stall_cnt4), BW'(st4));
    ix      = in_valid && exp_ready();
    ox      = (q.size() > 0) && out_ready;
    stalled = (q.size() > 0) && !out_ready;
    @(posedge clk);
    model_edge(ix, ox, stalled);
    #1;
  endtask

  initial begin
    int n;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    model_edge(1'b0, 1'b0, 1'b0);
    #1;
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();

    // Single entry with downstream ready.
    drive(1'b1, 32'h0041_0093, BW'(32'h10), 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();

    // Back-pressure with three pending entries, then release.
    n = 1;
    for (int g = 0; g < 6; g++) begin
      if (n <= 3) begin
        drive(1'b1, DW'(n), BW'(n * 16), 1'b0, 1'b0, 1'b0);
        if (exp_ready()) n++;
      end else begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      end
      tick();
    end
    for (int g = 0; g < 8; g++) begin
      if (n <= 3) begin
        drive(1'b1, DW'(n), BW'(n * 16), 1'b0, 1'b1, 1'b0);
        if (exp_ready()) n++;
      end else begin
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      end
      tick();
    end
    check("all_three_accepted", BW'(n), BW'(4));

    // Fill the stage, then flush together with an incoming entry.
    for (int g = 0; g < 3; g++) begin
      drive(1'b1, DW'(32'h100 + g), BW'(g), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hDEAD_BEEF, {BW{1'b1}}, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();

    // Saturation of the narrow stall counter from a fresh reset.
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h77, BW'(32'h7), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 20; g++) tick();
    @(negedge clk);
    check("stall4_saturated", BW'(stall_cnt4), BW'(4'd15));
    check("stall16_count", BW'(stall_cnt), BW'(20));
    @(posedge clk);
    model_edge(1'b0, 1'b0, 1'b1);
    #1;

    // Clear while stalled, then push into the emptied stage.
    drive(1'b1, 32'h55, BW'(32'h5), 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h66, BW'(32'h6), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();

    // Back-to-back streaming with downstream always ready.
    n = 0;
    for (int g = 0; g < 8; g++) begin
      drive(1'b1, DW'(32'h200 + n), BW'(n), 1'b0, 1'b1, 1'b0);
      if (exp_ready()) n++;
      tick();
    end
    check("stream_rate", BW'(n), BW'(8));
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();

    // Random traffic.
    for (int g = 0; g < 400; g++) begin
      drive(($urandom % 4) != 0, $urandom, {$urandom, $urandom, $urandom},
            ($urandom % 25) == 0, ($urandom % 3) != 0, ($urandom % 60) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
